// File: rtl/rc4_stream_core.sv
// RC4 keystream generator: 256x8 S-box in registers, INIT -> KSA -> PRGA, valid/ready byte output.
// Optional RC4_DROP_EN macro discards the first DROP_N keystream bytes after KSA.
module rc4_stream_core #(
  parameter int MAX_KEY_BYTES = 16,
  parameter int DROP_N        = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [8*MAX_KEY_BYTES-1:0] key,
  input  logic [7:0]                 key_len,
  output logic                       key_err,
  output logic                       busy,
  output logic [7:0]                 ks_data,
  output logic                       ks_valid,
  input  logic                       ks_ready
);
  localparam int KW = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, INIT, KSA_J, KSA_SW, P_I, P_J, P_SW, OUT} state_t;

  state_t                     state, state_nx;
  logic [7:0]                 sbox [256];
  logic [7:0]                 i, j, n, i_nx, j_nx, n_nx, ks_data_nx;
  logic                       ks_valid_nx, key_err_nx;
  logic [8*MAX_KEY_BYTES-1:0] key_r;
  logic [7:0]                 key_len_r;
  logic [KW-1:0]              kidx, kidx_nx;
  logic                       latch, wr_init, wr_swap, key_ok, dropping;
  logic [7:0]                 si, sj, idx, sidx, kbyte, ks_post;

  assign si    = sbox[i];
  assign sj    = sbox[j];
  assign idx   = si + sj;
  assign sidx  = sbox[idx];
  assign kbyte = key_r[{kidx, 3'b000} +: 8];
  // Output byte is read from the post-swap S-box, but the swap lands at the same edge.
  assign ks_post = (idx == i) ? sj : (idx == j) ? si : sidx;
  assign key_ok  = (key_len != 8'd0) && ({1'b0, key_len} <= 9'(MAX_KEY_BYTES));
  assign busy    = (state != IDLE);

`ifdef RC4_DROP_EN
  logic [8:0] drop_cnt, drop_nx;
  assign dropping = (drop_cnt < 9'(DROP_N));
`else
  logic unused_drop;
  assign unused_drop = |DROP_N;
  assign dropping    = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    i_nx        = i;
    j_nx        = j;
    n_nx        = n;
    kidx_nx     = kidx;
    ks_data_nx  = ks_data;
    ks_valid_nx = ks_valid;
    key_err_nx  = 1'b0;
    latch       = 1'b0;
    wr_init     = 1'b0;
    wr_swap     = 1'b0;
`ifdef RC4_DROP_EN
    drop_nx     = drop_cnt;
`endif
    case (state)
      IDLE: if (start) begin
        if (key_ok) begin
          latch    = 1'b1;
          n_nx     = 8'd0;
          state_nx = INIT;
        end else key_err_nx = 1'b1;
      end
      INIT: begin
        wr_init = 1'b1;
        n_nx    = n + 8'd1;
        if (n == 8'hFF) begin
          state_nx = KSA_J;
          i_nx     = 8'd0;
          j_nx     = 8'd0;
          kidx_nx  = '0;
        end
      end
      KSA_J: begin
        j_nx     = j + si + kbyte;
        state_nx = KSA_SW;
      end
      KSA_SW: begin
        wr_swap = 1'b1;
        i_nx    = i + 8'd1;
        kidx_nx = (8'(kidx) == key_len_r - 8'd1) ? '0 : kidx + KW'(1);
        if (i == 8'hFF) begin
          j_nx     = 8'd0;
          state_nx = P_I;
`ifdef RC4_DROP_EN
          drop_nx  = 9'd0;
`endif
        end else state_nx = KSA_J;
      end
      P_I: begin
        i_nx     = i + 8'd1;
        state_nx = P_J;
      end
      P_J: begin
        j_nx     = j + si;
        state_nx = P_SW;
      end
      P_SW: begin
        wr_swap = 1'b1;
        if (dropping) begin
          state_nx = P_I;
`ifdef RC4_DROP_EN
          drop_nx  = drop_cnt + 9'd1;
`endif
        end else begin
          ks_data_nx  = ks_post;
          ks_valid_nx = 1'b1;
          state_nx    = OUT;
        end
      end
      OUT: if (ks_ready) begin
        ks_valid_nx = 1'b0;
        state_nx    = P_I;
      end
      default: state_nx = IDLE;
    endcase
    // Abort wins over everything, and leaves the S-box untouched.
    if (stop) begin
      state_nx    = IDLE;
      i_nx        = 8'd0;
      j_nx        = 8'd0;
      n_nx        = 8'd0;
      ks_data_nx  = 8'd0;
      ks_valid_nx = 1'b0;
      key_err_nx  = 1'b0;
      latch       = 1'b0;
      wr_init     = 1'b0;
      wr_swap     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      i         <= 8'd0;
      j         <= 8'd0;
      n         <= 8'd0;
      kidx      <= '0;
      ks_data   <= 8'd0;
      ks_valid  <= 1'b0;
      key_err   <= 1'b0;
      key_r     <= '0;
      key_len_r <= 8'd0;
`ifdef RC4_DROP_EN
      drop_cnt  <= 9'd0;
`endif
    end else begin
      state    <= state_nx;
      i        <= i_nx;
      j        <= j_nx;
      n        <= n_nx;
      kidx     <= kidx_nx;
      ks_data  <= ks_data_nx;
      ks_valid <= ks_valid_nx;
      key_err  <= key_err_nx;
`ifdef RC4_DROP_EN
      drop_cnt <= drop_nx;
`endif
      if (latch) begin
        key_r     <= key;
        key_len_r <= key_len;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_init) sbox[n] <= n;
    if (wr_swap) begin
      sbox[i] <= sj;
      sbox[j] <= si;
    end
  end
endmodule
